// File: rtl/uart_pkg.sv
// Shared UART constants and FIFO flag helpers.
// Used by the TX and RX FIFO instances.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_AW    = 4;
  localparam int UART_AFULL_LVL  = 12;
  localparam int UART_AEMPTY_LVL = 2;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  function automatic fifo_flags_t fifo_flags(
    input int unsigned cnt,
    input int unsigned depth,
    input int unsigned afl,
    input int unsigned ael
  );
    fifo_flags_t f;
    f.full   = (cnt == depth);
    f.empty  = (cnt == 0);
    f.afull  = (cnt >= afl);
    f.aempty = (cnt <= ael);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM, registered read with read enable.
// The read register holds its word until the next enabled read.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) mem[w_addr] <= w_data;
    if (r_en) r_data <= mem[r_addr];
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO controller around fifo_ram.
// Registered flags, sticky errors, flush and optional FWFT output.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_FIFO_AW,
  parameter int AFULL_LVL  = UART_AFULL_LVL,
  parameter int AEMPTY_LVL = UART_AEMPTY_LVL,
  parameter bit FWFT       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  wr_acc;
  logic                  ram_rd;
  logic                  pend;
  logic                  pend_nxt;
  logic                  load;
  logic                  vld_nxt;
  logic                  dec;
  logic                  rd_bad;
  fifo_flags_t           flags_nxt;

`ifndef SYNTHESIS
  if (!(AEMPTY_LVL > 0 && AEMPTY_LVL < AFULL_LVL &&
        AFULL_LVL <= DEPTH)) begin : g_bad_lvl
    $error("uart_sync_fifo: illegal AFULL_LVL/AEMPTY_LVL");
  end
`endif

  assign wr_acc = w_en && !full;

  // pend: the RAM read register holds a word not yet moved to r_data
  if (FWFT) begin : g_fwft
    logic pop;
    logic ram_avail;
    assign ram_avail = (wr_ptr != rd_ptr);
    assign pop       = r_en && r_valid;
    assign load      = pend && (!r_valid || pop);
    assign ram_rd    = ram_avail && (!pend || load);
    assign pend_nxt  = ram_rd || (pend && !load);
    assign vld_nxt   = load || (r_valid && !pop);
    assign dec       = pop;
    assign rd_bad    = r_en && !r_valid;
  end else begin : g_std
    assign ram_rd    = r_en && !empty;
    assign load      = pend;
    assign pend_nxt  = ram_rd;
    assign vld_nxt   = pend;
    assign dec       = ram_rd;
    assign rd_bad    = r_en && empty;
  end

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, dec})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  assign flags_nxt = fifo_flags(32'(count_nxt), DEPTH,
                                AFULL_LVL, AEMPTY_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pend      <= 1'b0;
      r_valid   <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      if (load)   r_data <= ram_data;
      count   <= count_nxt;
      pend    <= pend_nxt;
      r_valid <= vld_nxt;
      {full, empty, afull, aempty} <= flags_nxt;
      if (w_en && full) overflow  <= 1'b1;
      if (rd_bad)       underflow <= 1'b1;
    end
  end

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_DEPTH (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .w_en  (wr_acc && !flush),
    .w_addr(wr_ptr[ADDR_WIDTH-1:0]),
    .w_data(w_data),
    .r_en  (ram_rd && !flush),
    .r_addr(rd_ptr[ADDR_WIDTH-1:0]),
    .r_data(ram_data)
  );

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Bench for uart_sync_fifo: FWFT=0 and FWFT=1 instances,
// vector table plus scoreboard of written words.
module tb_uart_sync_fifo;

  logic            clk;
  logic            rst_n;
  logic [1:0]      flush;
  logic [1:0]      w_en;
  logic [1:0]      r_en;
  logic [1:0][7:0] w_data;
  logic [1:0][7:0] r_data;
  logic [1:0]      r_valid;
  logic [1:0]      full;
  logic [1:0]      empty;
  logic [1:0]      afull;
  logic [1:0]      aempty;
  logic [1:0][4:0] count;
  logic [1:0]      overflow;
  logic [1:0]      underflow;

  typedef struct {
    logic       w_en;
    logic [7:0] w_data;
    logic [4:0] count;
    logic       full;
    logic       afull;
    logic       aempty;
    logic       overflow;
  } vec_t;

  vec_t       vecs [17];
  logic [7:0] q [$];
  int         mcount;
  int         cur;
  int         pops;
  int         n_chk;
  int         n_pass;

  uart_sync_fifo #(.FWFT(1'b0)) u_std (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush[0]),
    .w_en     (w_en[0]),
    .w_data   (w_data[0]),
    .r_en     (r_en[0]),
    .r_data   (r_data[0]),
    .r_valid  (r_valid[0]),
    .full     (full[0]),
    .empty    (empty[0]),
    .afull    (afull[0]),
    .aempty   (aempty[0]),
    .count    (count[0]),
    .overflow (overflow[0]),
    .underflow(underflow[0])
  );

  uart_sync_fifo #(.FWFT(1'b1)) u_fwft (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush[1]),
    .w_en     (w_en[1]),
    .w_data   (w_data[1]),
    .r_en     (r_en[1]),
    .r_data   (r_data[1]),
    .r_valid  (r_valid[1]),
    .full     (full[1]),
    .empty    (empty[1]),
    .afull    (afull[1]),
    .aempty   (aempty[1]),
    .count    (count[1]),
    .overflow (overflow[1]),
    .underflow(underflow[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (fwft=%0d): got %0h expected %0h",
                  nm, cur, act, exp);
  endfunction

  function automatic void sb_check(input logic [7:0] d);
    pops++;
    if (q.size() == 0) chk("sb_extra_word", 32'(d), 32'hFFFF_FFFF);
    else chk("sb_data", 32'(d), 32'(q.pop_front()));
  endfunction

  task automatic step();
    bit wacc;
    bit racc;
    wacc = w_en[cur] && !flush[cur] && mcount < 16;
    if (cur == 1) racc = r_en[1] && r_valid[1] && !flush[1];
    else          racc = r_en[0] && mcount > 0 && !flush[0];
    if (cur == 1 && racc) sb_check(r_data[1]);
    if (flush[cur]) begin
      q.delete();
      mcount = 0;
    end else begin
      if (wacc) q.push_back(w_data[cur]);
      mcount += int'(wacc) - int'(racc);
    end
    @(posedge clk);
    #1;
    if (cur == 0 && r_valid[0]) sb_check(r_data[0]);
    chk("count", 32'(count[cur]), 32'(mcount));
  endtask

  task automatic idle(input int n);
    w_en[cur] = 1'b0;
    r_en[cur] = 1'b0;
    flush[cur] = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic read_n(input int n);
    r_en[cur] = 1'b1;
    for (int i = 0; i < n; i++) step();
    r_en[cur] = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    w_en[cur] = 1'b1;
    w_data[cur] = d;
    step();
    w_en[cur] = 1'b0;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_flags"},
        32'({full[cur], empty[cur], afull[cur], aempty[cur],
             r_valid[cur], overflow[cur], underflow[cur]}),
        32'b0101000);
    chk({nm, "_count"}, 32'(count[cur]), 0);
    chk({nm, "_rdata"}, 32'(r_data[cur]), 0);
  endtask

  task automatic do_reset(input bit check);
    flush = '0;
    w_en  = '0;
    r_en  = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    if (check) chk_reset("reset");
    rst_n = 1'b1;
    q.delete();
    mcount = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    mcount = 0;
    pops   = 0;
    cur    = 0;
    rst_n  = 1'b0;
    flush  = '0;
    w_en   = '0;
    r_en   = '0;
    w_data = '0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].w_en     = 1'b1;
      vecs[i].w_data   = (i < 16) ? 8'(i + 1) : 8'hAA;
      vecs[i].count    = (i < 16) ? 5'(i + 1) : 5'd16;
      vecs[i].full     = (i >= 15);
      vecs[i].afull    = (i >= 11);
      vecs[i].aempty   = (i <= 1);
      vecs[i].overflow = (i == 16);
    end

    for (int m = 0; m < 2; m++) begin
      cur = m;

      // fill to full, then one overflowing write
      do_reset(1'b1);
      for (int i = 0; i < 17; i++) begin
        w_en[cur]   = vecs[i].w_en;
        w_data[cur] = vecs[i].w_data;
        step();
        chk("fill_count", 32'(count[cur]), 32'(vecs[i].count));
        chk("fill_flags",
            32'({full[cur], afull[cur], aempty[cur], overflow[cur]}),
            32'({vecs[i].full, vecs[i].afull,
                 vecs[i].aempty, vecs[i].overflow}));
      end
      idle(3);
      pops = 0;
      read_n(16);
      idle(3);
      chk("fill_pops", pops, 16);
      chk("fill_drained", 32'({empty[cur], underflow[cur],
                               overflow[cur]}), 32'b101);

      // single-word latency
      do_reset(1'b0);
      if (cur == 0) begin
        write_word(8'h5A);
        idle(1);
        r_en[cur] = 1'b1;
        step();
        r_en[cur] = 1'b0;
        chk("std_accept", 32'({count[0], empty[0], r_valid[0]}),
            32'({5'd0, 1'b1, 1'b0}));
        step();
        chk("std_valid", 32'({r_valid[0], r_data[0]}), 32'h15A);
        step();
        chk("std_hold", 32'({r_valid[0], r_data[0]}), 32'h05A);
      end else begin
        write_word(8'h3C);
        chk("fwft_n0", 32'(r_valid[1]), 0);
        step();
        chk("fwft_n1", 32'(r_valid[1]), 0);
        step();
        chk("fwft_n2", 32'({r_valid[1], r_data[1]}), 32'h13C);
        for (int i = 0; i < 7; i++) write_word(8'h41 + 8'(i));
        idle(1);
        pops = 0;
        read_n(8);
        chk("fwft_burst_pops", pops, 8);
        idle(2);
        chk("fwft_burst_end", 32'({empty[1], underflow[1]}), 32'b10);
      end

      // pointer wrap at constant occupancy
      begin
        int k;
        int bad;
        do_reset(1'b0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
          write_word(8'(k));
          k++;
        end
        idle(3);
        bad = 0;
        pops = 0;
        for (int i = 0; i < 40; i++) begin
          w_en[cur] = 1'b1;
          r_en[cur] = 1'b1;
          w_data[cur] = 8'(k);
          k++;
          step();
          if (count[cur] != 5'd8 ||
              {full[cur], empty[cur], afull[cur], aempty[cur],
               overflow[cur], underflow[cur]} != 6'b0)
            bad++;
        end
        w_en[cur] = 1'b0;
        r_en[cur] = 1'b0;
        chk("wrap_stable", bad, 0);
        read_n(8);
        idle(3);
        chk("wrap_pops", pops, 48);
        chk("wrap_left", q.size(), 0);
      end

      // underflow, then flush beating a write
      do_reset(1'b0);
      r_en[cur] = 1'b1;
      step();
      r_en[cur] = 1'b0;
      chk("underflow_set", 32'({underflow[cur], count[cur]}),
          32'({1'b1, 5'd0}));
      flush[cur] = 1'b1;
      w_en[cur] = 1'b1;
      w_data[cur] = 8'hEE;
      step();
      flush[cur] = 1'b0;
      w_en[cur] = 1'b0;
      chk("flush_state",
          32'({count[cur], underflow[cur], empty[cur], r_valid[cur]}),
          32'({5'd0, 1'b0, 1'b1, 1'b0}));
      idle(3);
      chk("flush_no_write", 32'({count[cur], empty[cur]}),
          32'({5'd0, 1'b1}));

      // async reset mid-burst
      do_reset(1'b0);
      for (int i = 0; i < 9; i++) write_word(8'h90 + 8'(i));
      idle(2);
      chk("pre_reset_count", 32'(count[cur]), 9);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("async_reset");
      q.delete();
      mcount = 0;
      #1;
      rst_n = 1'b1;
      write_word(8'h77);
      write_word(8'h78);
      idle(3);
      pops = 0;
      read_n(2);
      idle(3);
      chk("post_reset_pops", pops, 2);
      chk("post_reset_empty", 32'(empty[cur]), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
